// File: rtl/rst_seq_pkg.sv
// Shared state encoding, request-source indices and sizing helpers
// for the reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } rst_seq_state_e;

    localparam int REQ_EXT  = 0;
    localparam int REQ_PROG = 1;
    localparam int REQ_WDOG = 2;
    localparam int REQ_SW   = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One spare bit so the terminal compare never sits on a wrap boundary.
    function automatic int cnt_width(input int hold, input int stage);
        return $clog2(max_int(hold, stage)) + 1;
    endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Clearable, holdable up-counter with a terminal-count compare; shared by
// the hold phase and the staged-release phase of the sequencer.
module rst_seq_timer #(
    parameter int Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             hold_i,
    input  logic [Width-1:0] tc_i,
    output logic             done_o
);

    logic [Width-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (!hold_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign done_o = (cnt_q == tc_i);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: asserts all domain resets on any unmasked request, holds
// them, then releases domains in order; records which sources fired.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NumReq     = 4,
    parameter int NumDomains = 3,
    parameter int HoldCycles = 8,
    parameter int StageDelay = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NumReq-1:0]     req_i,
    input  logic [NumReq-1:0]     req_mask_i,
    input  logic                  cause_clr_i,
    output logic [NumDomains-1:0] domain_rst_no,
    output logic                  busy_o,
    output logic [NumReq-1:0]     cause_o
);

    localparam int CntW = cnt_width(HoldCycles, StageDelay);
    localparam int IdxW = (NumDomains > 1) ? $clog2(NumDomains) : 1;
    localparam logic [CntW-1:0] HoldTc    = CntW'(HoldCycles - 1);
    localparam logic [CntW-1:0] StageTc   = CntW'(StageDelay - 1);
    localparam logic [IdxW-1:0] PenultIdx = IdxW'((NumDomains > 1) ? NumDomains - 2 : 0);

    rst_seq_state_e        state_q, state_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic                  cnt_clr, cnt_hold, cnt_done;
    logic [CntW-1:0]       cnt_tc;
    logic [NumReq-1:0]     eff_bits;
    logic                  eff_req;
    logic [NumDomains-1:0] domain_d;
    logic                  busy_d;

    assign eff_bits = req_i & ~req_mask_i;
    assign eff_req  = |eff_bits;

    rst_seq_timer #(
        .Width (CntW)
    ) u_timer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (cnt_clr),
        .hold_i (cnt_hold),
        .tc_i   (cnt_tc),
        .done_o (cnt_done)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ASSERT;
            idx_q         <= '0;
            domain_rst_no <= '0;
            busy_o        <= 1'b1;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            domain_rst_no <= domain_d;
            busy_o        <= busy_d;
        end
    end

    // NOTE: every signal written here gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_clr  = 1'b0;
        cnt_hold = 1'b0;
        cnt_tc   = HoldTc;
        unique case (state_q)
            ASSERT: begin
                idx_d = '0;
                if (eff_req) begin
                    cnt_clr = 1'b1;
                end else if (cnt_done) begin
                    cnt_clr = 1'b1;
                    state_d = (NumDomains > 1) ? RELEASE : RUN;
                end
            end
            RELEASE: begin
                cnt_tc = StageTc;
                if (eff_req) begin
                    cnt_clr = 1'b1;
                    idx_d   = '0;
                    state_d = ASSERT;
                end else if (cnt_done) begin
                    cnt_clr = 1'b1;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == PenultIdx) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                cnt_hold = 1'b1;
                if (eff_req) begin
                    cnt_clr = 1'b1;
                    idx_d   = '0;
                    state_d = ASSERT;
                end
            end
            default: begin
                cnt_clr = 1'b1;
                idx_d   = '0;
                state_d = ASSERT;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered nets change on the deciding edge.
    always_comb begin
        domain_d = '0;
        busy_d   = 1'b1;
        unique case (state_d)
            RUN: begin
                domain_d = '1;
                busy_d   = 1'b0;
            end
            RELEASE: begin
                for (int k = 0; k < NumDomains; k++) begin
                    domain_d[k] = (k <= int'(idx_d));
                end
            end
            default: begin
                domain_d = '0;
                busy_d   = 1'b1;
            end
        endcase
    end

    // A clear and a new request in the same cycle keep only the new bits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cause_o <= '0;
        end else begin
            cause_o <= (cause_clr_i ? '0 : cause_o) | eff_bits;
        end
    end

endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Reset sequencer for the Azadi SoC. It collects reset requests from several sources: external pin, programming interface, watchdog and software. It asserts a set of per-domain active-low resets together, holds them for a minimum time, then releases the domains one at a time in fixed order with a programmable gap. It sits between the raw reset/request sources and the domain reset nets, including the system reset that excludes the debug module, and records which source caused the last reset.

## Interface
Parameters:
- NumReq, 4: number of reset request sources.
- NumDomains, 3: number of reset domains. Domain 0 is released first.
- HoldCycles, 8: minimum all-asserted time in cycles. Must be ≥1.
- StageDelay, 4: cycles between consecutive domain releases. Must be ≥1.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, synchronous, active-high.
- req_i  in  NumReq  level reset requests, synchronous to clk_i, active-high.
- req_mask_i  in  NumReq  1 = ignore the corresponding req_i bit (quasi-static config).
- cause_clr_i  in  1  single-cycle pulse that clears cause_o.
- domain_rst_no  out  NumDomains  per-domain reset, active-low, registered.
- busy_o  out  1  high while any domain is held in reset, registered.
- cause_o  out  NumReq  sticky record of the sources that triggered resets, registered.

## Operation
- Effective request: eff_req = |(req_i & ~req_mask_i).
- FSM states: ASSERT, RELEASE, RUN.
- ASSERT
  - All domain_rst_no = 0; busy_o = 1.
  - While eff_req = 1, cnt is held at 0.
  - Otherwise cnt increments each cycle.
  - When cnt == HoldCycles-1: go to RELEASE, set idx = 0, release domain 0 on that edge, and clear cnt.
- RELEASE
  - Domains 0..idx are released; busy_o = 1.
  - cnt increments each cycle.
  - When cnt == StageDelay-1: increment idx, release domain idx, clear cnt.
  - On the edge that releases domain NumDomains-1: go to RUN and set busy_o = 0.
  - eff_req = 1 in any RELEASE cycle aborts the sequence: all domains re-assert, go to ASSERT, cnt = 0.
- RUN
  - All domain_rst_no = 1; busy_o = 0.
  - eff_req = 1: all domains assert on the next edge, go to ASSERT, cnt = 0.
- Cause capture
  - On any edge where eff_req = 1, cause_o |= (req_i & ~req_mask_i). This applies in every state.
  - cause_clr_i clears cause_o.
  - If a new request and cause_clr_i occur in the same cycle, the new bits are set; all other bits clear.
- Masked requests have no effect on the FSM or on cause_o.
- Counter width is $clog2(max(HoldCycles, StageDelay))+1. The counter never wraps because it is cleared on every transition.

## Timing
- rst_i = 1 sampled at an edge gives, after that edge: state ASSERT, cnt = 0, idx = 0, domain_rst_no = all 0, busy_o = 1, cause_o = 0.
- Let E0 be the first edge at which rst_i = 0 is sampled, with eff_req = 0 from then on.
  - Domain k goes high after edge E0 + HoldCycles-1 + k·StageDelay.
  - busy_o falls after the same edge that releases the last domain.
- Request-to-assert latency is 1 edge: eff_req sampled at edge N gives all domain_rst_no = 0 after edge N.
- A request held for L cycles gives an all-asserted time of L + HoldCycles - 1 cycles. The hold is measured from request deassertion.
- rst_i asserted mid-sequence overrides everything, including cause capture.

## Structure
- Package rst_seq_pkg contains:
  - rst_seq_state_e: ASSERT, RELEASE, RUN, 2-bit encoding.
  - Request index constants: REQ_EXT = 0, REQ_PROG = 1, REQ_WDOG = 2, REQ_SW = 3.
- One sub-module, rst_seq_timer: a clearable, holdable up-counter with a terminal-count compare input, shared by the ASSERT and RELEASE states.
- FSM, idx register and cause register live in rst_seq_ctrl.

## Test plan
Default parameters (NumReq 4, NumDomains 3, HoldCycles 8, StageDelay 4) unless stated.
1. Power-up: hold rst_i 3 cycles, then drop it.
   - Required: domains 0/1/2 rise after edges E0+7 / E0+11 / E0+15.
   - Required: busy_o falls with domain 2; cause_o = 0.
2. Run-time request: in RUN, pulse req_i = 4'b0100 for 1 cycle.
   - Required: all domains low on the next edge, re-release at the same spacing as test 1 measured from the pulse edge.
   - Required: cause_o = 4'b0100.
3. Abort: assert req_i[0] two cycles after domain 0 is released.
   - Required: domain 0 re-asserts next edge.
   - Required: sequence restarts; domain 1 never goes high before the new hold expires.
4. Masking: req_mask_i = 4'b1000, pulse req_i = 4'b1000 in RUN.
   - Required: no reset; cause_o unchanged.
   - Then unmask and repeat: required reset, cause_o[3] = 1.
5. Long request: hold req_i[1] for 20 cycles.
   - Required: domain 0 rises 7 edges after req_i[1] falls.
6. Clear collision: cause_o = 4'b0001; pulse cause_clr_i together with req_i = 4'b0010.
   - Required: cause_o = 4'b0010.
